// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM-like bus arbiter.
// Owner tags, lock states, transfer sizes and the request bundle.
package sram_bus_arbiter_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_INST = 2'd1,
        LK_DATA = 2'd2
    } lock_e;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    function automatic lock_e lock_of(input logic owner);
        return (owner == OWN_DATA) ? LK_DATA : LK_INST;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// Owner FIFO: one bit per accepted-but-incomplete transaction.
// Head tells which requester the next data_ok belongs to.
module sram_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       push_owner,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic                       head,
    output logic [$clog2(DEPTH+1)-1:0] count_nxt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_nxt = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_owner;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between inst fetch and the memory stage.
// Data has priority; a streak bound keeps inst from starving.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        arb_busy,
    output logic        arb_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [2:0] STREAK_MAX = 3'(MAX_DATA_STREAK);

    lock_e     state;
    lock_e     state_nxt;
    sram_req_t inst_bus;
    sram_req_t data_bus;
    sram_req_t gnt_bus;
    logic      gnt_valid;
    logic      gnt_owner;
    logic      inst_force;
    logic [2:0] streak_cnt;
    logic      hs_inst;
    logic      hs_data;
    logic      pop_ok;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_head;
    logic [CW-1:0] fifo_count_nxt;

    assign inst_bus = '{req: inst_req, wr: inst_wr, size: inst_size,
                        addr: inst_addr, wdata: inst_wdata};
    assign data_bus = '{req: data_req, wr: data_wr, size: data_size,
                        addr: data_addr, wdata: data_wdata};

    assign inst_force = inst_req && (streak_cnt == STREAK_MAX);

    // Grant decode: fixed while locked, priority pick when free
    always_comb begin
        gnt_valid = 1'b0;
        gnt_owner = OWN_DATA;
        unique case (state)
            LK_NONE: begin
                priority case (1'b1)
                    inst_force: begin
                        gnt_valid = 1'b1;
                        gnt_owner = OWN_INST;
                    end
                    data_req: begin
                        gnt_valid = 1'b1;
                        gnt_owner = OWN_DATA;
                    end
                    inst_req: begin
                        gnt_valid = 1'b1;
                        gnt_owner = OWN_INST;
                    end
                    default: ;
                endcase
            end
            LK_INST: begin
                gnt_valid = 1'b1;
                gnt_owner = OWN_INST;
            end
            LK_DATA: begin
                gnt_valid = 1'b1;
                gnt_owner = OWN_DATA;
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt_bus = '0;
        if (gnt_valid) begin
            gnt_bus = (gnt_owner == OWN_DATA) ? data_bus : inst_bus;
        end
    end

    assign bus_req   = cpu_rst_n && gnt_valid && gnt_bus.req && !fifo_full;
    assign bus_wr    = cpu_rst_n && gnt_bus.wr;
    assign bus_size  = cpu_rst_n ? gnt_bus.size  : '0;
    assign bus_addr  = cpu_rst_n ? gnt_bus.addr  : '0;
    assign bus_wdata = cpu_rst_n ? gnt_bus.wdata : '0;

    assign hs_inst = bus_req && bus_addr_ok && (gnt_owner == OWN_INST);
    assign hs_data = bus_req && bus_addr_ok && (gnt_owner == OWN_DATA);

    assign inst_addr_ok = hs_inst;
    assign data_addr_ok = hs_data;

    assign pop_ok       = bus_data_ok && !fifo_empty;
    assign inst_data_ok = cpu_rst_n && pop_ok && (fifo_head == OWN_INST);
    assign data_data_ok = cpu_rst_n && pop_ok && (fifo_head == OWN_DATA);
    assign inst_rdata   = cpu_rst_n ? bus_rdata : '0;
    assign data_rdata   = cpu_rst_n ? bus_rdata : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            LK_NONE: begin
                if (bus_req && !bus_addr_ok) begin
                    state_nxt = lock_of(gnt_owner);
                end
            end
            LK_INST, LK_DATA: begin
                if (bus_addr_ok) begin
                    state_nxt = LK_NONE;
                end
            end
            default: state_nxt = LK_NONE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= LK_NONE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            streak_cnt <= '0;
        end else if (hs_inst || !inst_req) begin
            streak_cnt <= '0;
        end else if (hs_data && (streak_cnt != 3'd7)) begin
            streak_cnt <= streak_cnt + 3'd1;
        end
    end

    // A data_ok with nothing outstanding means the bridge lost sync
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            arb_busy <= 1'b0;
            arb_err  <= 1'b0;
        end else begin
            arb_busy <= (fifo_count_nxt != '0);
            if (bus_data_ok && fifo_empty) begin
                arb_err <= 1'b1;
            end
        end
    end

    sram_owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk        (cpu_clk_50M),
        .rst_n      (cpu_rst_n),
        .push       (hs_inst || hs_data),
        .push_owner (gnt_owner),
        .pop        (pop_ok),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head),
        .count_nxt  (fifo_count_nxt)
    );

endmodule
